fc_tree_sequencer: RTL and testbench
====================================

Name: fc_tree_sequencer

Overview:
Controller for one fully-connected layer built around the FP16 multiply-add lanes and their adder tree. It splits each output neuron's dot product into chunks of MULT_ADD_UNITS inputs and issues one chunk per cycle to the activation and weight buffers. A tag pipeline matches the buffer plus tree latency, so the block drives the accumulator controls (load, accumulate) and flags each finished neuron. It sits between the layer-level scheduler (start/done) and the FC datapath.

Parameters:
DATAWIDTH, 16, element width (FP16); only used for documentation and consistency checks
MULT_ADD_UNITS, 16, lanes per chunk (U); also the adder-tree width
MAX_IN, 1024, maximum input features per neuron
MAX_OUT, 64, maximum output neurons
RD_LAT, 1, buffer read latency in cycles
TREE_LAT, 4, multiplier plus adder-tree latency in cycles; PIPE_LAT = RD_LAT + TREE_LAT
CHUNK_W, clog2(ceil(MAX_IN/U)), chunk index width (derived)
OUT_W, clog2(MAX_OUT), neuron index width (derived)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle request to run a layer; only honoured in IDLE
num_in  in  clog2(MAX_IN+1)  input feature count; latched at start
num_out  in  clog2(MAX_OUT+1)  output neuron count; latched at start
rd_en  out  1  buffer read strobe for one chunk
in_addr  out  CHUNK_W  activation chunk index
w_addr  out  OUT_W+CHUNK_W  weight chunk index, neuron*C + chunk
lane_mask  out  U  per-lane enable; a 0 lane forces a zero product into the tree
acc_load  out  1  accumulator <= tree result (first chunk of a neuron)
acc_en  out  1  accumulator <= accumulator + tree result (later chunks)
out_valid  out  1  accumulator holds the final sum for out_idx
out_idx  out  OUT_W  neuron index of the current result
busy  out  1  high from start acceptance until done
done  out  1  one-cycle layer-complete pulse

Behaviour:
- Reset values:
  - All outputs are 0, the state is IDLE, and the tag pipeline is cleared.
  - Reset mid-operation aborts immediately. No further strobes are issued and done does not pulse.
- C = ceil(num_in/U), computed at start. All outputs are registered.
- States: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
  - IDLE: start=1 latches num_in and num_out, sets busy, and enters RUN. If num_in==0 or num_out==0 it goes directly to DONE.
  - RUN: each cycle asserts rd_en with chunk counter k and neuron counter n.
    - in_addr = k, w_addr = n*C + k.
    - k wraps from C-1 to 0 and n then increments.
    - After issuing (n=num_out-1, k=C-1) the state moves to DRAIN. Total issues = num_out*C, with no gaps.
  - DRAIN: waits until the tag pipeline is empty and the final out_valid has been emitted, then moves to DONE.
  - DONE: pulses done for one cycle, clears busy, and returns to IDLE.
- lane_mask:
  - All ones, except on chunk k=C-1 when num_in mod U = r != 0.
  - In that case only lanes 0..r-1 are set (e.g. r=4 gives 0x000F).
- Tag pipeline:
  - Depth PIPE_LAT; each tag is {valid, first, last, n}.
  - A tag is written in the rd_en cycle and emerges PIPE_LAT cycles later.
  - On emergence: first=1 drives acc_load, otherwise acc_en. These are never asserted together.
  - If last=1, out_valid is asserted with out_idx=n on the following cycle.
  - If C==1, every tag has first=last=1.
- Simultaneous events:
  - out_valid for neuron n may coincide with acc_load for neuron n+1. The datapath reads the accumulator before it is overwritten.
  - start while busy is ignored.
  - start in the same cycle as done is ignored. It is accepted from the following cycle.

Decomposition:
- Package fc_pkg holds:
  - the FP16 DATAWIDTH constant;
  - the tag struct typedef {valid, first, last, idx};
  - the state enum;
  - a ceil_div function.
- One natural sub-module, fc_tag_pipe: a parameterised-depth shift register of tags with reset clear, instantiated with PIPE_LAT.

Test Plan:
- U=16, PIPE_LAT=5, start with num_in=32, num_out=2 -> rd_en for 4 consecutive cycles starting the cycle after start.
  - w_addr = 0,1,2,3; in_addr = 0,1,0,1.
  - acc_load/acc_en/acc_load/acc_en 5 cycles after each issue.
  - out_valid with out_idx 0 then 1.
  - done pulses exactly once, one cycle after the last out_valid.
- num_in=20, num_out=1 -> C=2; lane_mask 0xFFFF then 0x000F; one out_valid.
- num_in=16, num_out=3 -> acc_load only (no acc_en); out_valid for out_idx 0,1,2 on consecutive cycles.
- num_out=0 -> no rd_en; done the cycle after DONE is entered; busy high for 2 cycles.
- Assert rst mid-RUN -> all outputs 0 asynchronously, no done, and a fresh start afterwards runs a clean layer.
- start pulses while busy -> ignored, with addresses unaffected; back-to-back start one cycle after done -> accepted.

Source files
------------

// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared types, constants and helpers for the FC tree sequencer
package fc_pkg;

    localparam int FC_DATAWIDTH = 16;
    localparam int FC_MAX_OUT   = 64;
    localparam int FC_IDX_W     = $clog2(FC_MAX_OUT);

    typedef struct packed {
        logic                valid;
        logic                first;
        logic                last;
        logic [FC_IDX_W-1:0] idx;
    } fc_tag_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } fc_state_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/fc_tag_pipe.sv
// rtl/fc_tag_pipe.sv - fixed-depth tag delay line matching buffer plus adder-tree latency
module fc_tag_pipe
    import fc_pkg::*;
#(
    parameter int DEPTH = 5
) (
    input  logic    clk,
    input  logic    rst,
    input  fc_tag_t tag_in,
    output fc_tag_t tag_out,
    output logic    any_valid
);

    fc_tag_t [DEPTH-1:0] stage_q;
    fc_tag_t [DEPTH-1:0] stage_d;

    always_comb begin
        stage_d    = stage_q;
        stage_d[0] = tag_in;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign tag_out = stage_q[DEPTH-1];

    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            any_valid = any_valid | stage_q[i].valid;
        end
    end

endmodule

// File: rtl/fc_tree_sequencer.sv
// rtl/fc_tree_sequencer.sv - chunk issue sequencer and accumulator control for one FC layer
module fc_tree_sequencer
    import fc_pkg::*;
#(
    parameter int MULT_ADD_UNITS = 16,
    parameter int MAX_IN         = 1024,
    parameter int MAX_OUT        = FC_MAX_OUT,
    parameter int RD_LAT         = 1,
    parameter int TREE_LAT       = 4,
    parameter int PIPE_LAT       = RD_LAT + TREE_LAT,
    parameter int CHUNK_W        = $clog2(ceil_div(MAX_IN, MULT_ADD_UNITS)),
    parameter int OUT_W          = $clog2(MAX_OUT),
    parameter int NIN_W          = $clog2(MAX_IN + 1),
    parameter int NOUT_W         = $clog2(MAX_OUT + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [NIN_W-1:0]          num_in,
    input  logic [NOUT_W-1:0]         num_out,
    output logic                      rd_en,
    output logic [CHUNK_W-1:0]        in_addr,
    output logic [OUT_W+CHUNK_W-1:0]  w_addr,
    output logic [MULT_ADD_UNITS-1:0] lane_mask,
    output logic                      acc_load,
    output logic                      acc_en,
    output logic                      out_valid,
    output logic [OUT_W-1:0]          out_idx,
    output logic                      busy,
    output logic                      done
);

    localparam int U  = MULT_ADD_UNITS;
    localparam int LW = $clog2(U);
    localparam int CW = CHUNK_W + 1;
    localparam int WW = OUT_W + CHUNK_W;

    fc_state_t          state_q, state_d;
    logic [CHUNK_W-1:0] k_q, k_d;
    logic [OUT_W-1:0]   n_q, n_d;
    logic [WW-1:0]      w_q, w_d;
    logic [CW-1:0]      c_q, c_d;
    logic [LW-1:0]      r_q, r_d;
    logic [NOUT_W-1:0]  nout_q, nout_d;
    logic               rd_en_q, rd_en_d;
    logic [U-1:0]       mask_q, mask_d;
    logic               acc_load_q, acc_load_d;
    logic               acc_en_q, acc_en_d;
    logic               acc_last_q, acc_last_d;
    logic [OUT_W-1:0]   acc_idx_q, acc_idx_d;
    logic               out_valid_q, out_valid_d;
    logic [OUT_W-1:0]   out_idx_q, out_idx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               last_k, last_n, issue_last;
    fc_tag_t            tag_d, tag_tail;
    logic               pipe_busy;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        n_d     = n_q;
        w_d     = w_q;
        c_d     = c_q;
        r_d     = r_q;
        nout_d  = nout_q;
        rd_en_d = 1'b0;
        mask_d  = mask_q;
        tag_d   = '0;
        last_k  = ({1'b0, k_q} == c_q - CW'(1));
        last_n  = (NOUT_W'(n_q) == nout_q - NOUT_W'(1));

        case (state_q)
            ST_IDLE: begin
                // the cycle carrying done still counts as busy, so start waits one more
                if (start && !done_q) begin
                    c_d    = CW'(ceil_div(int'(num_in), U));
                    r_d    = LW'(int'(num_in) % U);
                    nout_d = num_out;
                    k_d    = '0;
                    n_d    = '0;
                    w_d    = '0;
                    if (num_in == '0 || num_out == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                        rd_en_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (last_k && last_n) begin
                    state_d = ST_DRAIN;
                end else begin
                    rd_en_d = 1'b1;
                    w_d     = w_q + WW'(1);
                    if (last_k) begin
                        k_d = '0;
                        n_d = n_q + OUT_W'(1);
                    end else begin
                        k_d = k_q + CHUNK_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (!pipe_busy && acc_last_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        issue_last = ({1'b0, k_d} == c_d - CW'(1));
        if (rd_en_d) begin
            mask_d      = (issue_last && r_d != '0) ? ((U'(1) << r_d) - U'(1)) : '1;
            tag_d.valid = 1'b1;
            tag_d.first = (k_d == '0);
            tag_d.last  = issue_last;
            tag_d.idx   = n_d;
        end

        acc_load_d  = tag_tail.valid && tag_tail.first;
        acc_en_d    = tag_tail.valid && !tag_tail.first;
        acc_last_d  = tag_tail.valid && tag_tail.last;
        acc_idx_d   = tag_tail.valid ? tag_tail.idx : acc_idx_q;
        out_valid_d = acc_last_q;
        out_idx_d   = acc_last_q ? acc_idx_q : out_idx_q;
        done_d      = (state_q == ST_DONE);
        busy_d      = (state_d != ST_IDLE) || done_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            n_q         <= '0;
            w_q         <= '0;
            c_q         <= '0;
            r_q         <= '0;
            nout_q      <= '0;
            rd_en_q     <= 1'b0;
            mask_q      <= '0;
            acc_load_q  <= 1'b0;
            acc_en_q    <= 1'b0;
            acc_last_q  <= 1'b0;
            acc_idx_q   <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            n_q         <= n_d;
            w_q         <= w_d;
            c_q         <= c_d;
            r_q         <= r_d;
            nout_q      <= nout_d;
            rd_en_q     <= rd_en_d;
            mask_q      <= mask_d;
            acc_load_q  <= acc_load_d;
            acc_en_q    <= acc_en_d;
            acc_last_q  <= acc_last_d;
            acc_idx_q   <= acc_idx_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // tags enter alongside the registered rd_en so stage 0 lines up with the issue cycle
    fc_tag_pipe #(
        .DEPTH(PIPE_LAT)
    ) u_tag_pipe (
        .clk      (clk),
        .rst      (rst),
        .tag_in   (tag_d),
        .tag_out  (tag_tail),
        .any_valid(pipe_busy)
    );

    assign rd_en     = rd_en_q;
    assign in_addr   = k_q;
    assign w_addr    = w_q;
    assign lane_mask = mask_q;
    assign acc_load  = acc_load_q;
    assign acc_en    = acc_en_q;
    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_fc_tree_sequencer.sv
// tb/tb_fc_tree_sequencer.sv - scoreboard bench for fc_tree_sequencer
module tb_fc_tree_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [10:0] num_in = '0;
    logic [6:0]  num_out = '0;
    logic        rd_en;
    logic [5:0]  in_addr;
    logic [11:0] w_addr;
    logic [15:0] lane_mask;
    logic        acc_load;
    logic        acc_en;
    logic        out_valid;
    logic [5:0]  out_idx;
    logic        busy;
    logic        done;

    fc_tree_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .num_in   (num_in),
        .num_out  (num_out),
        .rd_en    (rd_en),
        .in_addr  (in_addr),
        .w_addr   (w_addr),
        .lane_mask(lane_mask),
        .acc_load (acc_load),
        .acc_en   (acc_en),
        .out_valid(out_valid),
        .out_idx  (out_idx),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int cyc; int in_addr; int w_addr; int mask;} rd_exp_t;
    typedef struct {int cyc; bit is_load;} acc_exp_t;
    typedef struct {int cyc; int idx;} out_exp_t;

    rd_exp_t  rd_q[$];
    acc_exp_t acc_q[$];
    out_exp_t out_q[$];
    int       done_q[$];
    int       busy_lo = 1;
    int       busy_hi = 0;
    int       errors = 0;
    int       checks = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, act, exp, cyc);
        end
    endtask

    task automatic push_layer(input int s, input int nin, input int nout);
        int c;
        int r;
        int total;
        if (nin == 0 || nout == 0) begin
            done_q.push_back(s + 2);
            busy_lo = s + 1;
            busy_hi = s + 2;
            return;
        end
        c     = (nin + 15) / 16;
        r     = nin % 16;
        total = nout * c;
        for (int i = 0; i < total; i++) begin
            int n = i / c;
            int k = i % c;
            rd_exp_t  re;
            acc_exp_t ae;
            out_exp_t oe;
            re.cyc     = s + 1 + i;
            re.in_addr = k;
            re.w_addr  = n * c + k;
            re.mask    = (k == c - 1 && r != 0) ? ((1 << r) - 1) : 'hFFFF;
            rd_q.push_back(re);
            ae.cyc     = s + 6 + i;
            ae.is_load = (k == 0);
            acc_q.push_back(ae);
            if (k == c - 1) begin
                oe.cyc = s + 7 + i;
                oe.idx = n;
                out_q.push_back(oe);
            end
        end
        done_q.push_back(s + 7 + total);
        busy_lo = s + 1;
        busy_hi = s + 7 + total;
    endtask

    always @(negedge clk) begin : mon
        bit       hit;
        rd_exp_t  re;
        acc_exp_t ae;
        out_exp_t oe;

        hit = (rd_q.size() > 0) && (rd_q[0].cyc == cyc);
        check("rd_en", rd_en, hit);
        if (hit) begin
            re = rd_q.pop_front();
            check("in_addr", in_addr, re.in_addr);
            check("w_addr", w_addr, re.w_addr);
            check("lane_mask", lane_mask, re.mask);
        end

        hit = (acc_q.size() > 0) && (acc_q[0].cyc == cyc);
        check("acc_excl", acc_load & acc_en, 1'b0);
        if (hit) begin
            ae = acc_q.pop_front();
            check("acc_load", acc_load, ae.is_load);
            check("acc_en", acc_en, !ae.is_load);
        end else begin
            check("acc_idle", {acc_load, acc_en}, 2'b00);
        end

        hit = (out_q.size() > 0) && (out_q[0].cyc == cyc);
        check("out_valid", out_valid, hit);
        if (hit) begin
            oe = out_q.pop_front();
            check("out_idx", out_idx, oe.idx);
        end

        hit = (done_q.size() > 0) && (done_q[0] == cyc);
        check("done", done, hit);
        if (hit) void'(done_q.pop_front());

        check("busy", busy, (cyc >= busy_lo) && (cyc <= busy_hi));
    end

    task automatic start_layer(input int nin, input int nout, output int s);
        @(negedge clk);
        num_in  = 11'(nin);
        num_out = 7'(nout);
        start   = 1'b1;
        s       = cyc;
        push_layer(s, nin, nout);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while ((rd_q.size() + acc_q.size() + out_q.size() + done_q.size()) != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("drain_timeout", rd_q.size() + acc_q.size() + out_q.size() + done_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int s;
        int d;

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_w_addr", w_addr, 0);
        check("rst_mask", lane_mask, 0);
        rst = 1'b0;

        start_layer(32, 2, s);  wait_done();
        start_layer(20, 1, s);  wait_done();
        start_layer(16, 3, s);  wait_done();
        start_layer(16, 0, s);  wait_done();
        start_layer(0, 5, s);   wait_done();

        start_layer(40, 3, s);
        for (int p = 0; p < 3; p++) begin
            repeat (3) @(negedge clk);
            num_in  = 11'd100;
            num_out = 7'd7;
            start   = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done();

        start_layer(64, 4, s);
        repeat (6) @(negedge clk);
        #3 rst = 1'b1;
        rd_q.delete();
        acc_q.delete();
        out_q.delete();
        done_q.delete();
        busy_lo = 1;
        busy_hi = 0;
        #1;
        check("arst_rd_en", rd_en, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_in_addr", in_addr, 0);
        check("arst_w_addr", w_addr, 0);
        check("arst_mask", lane_mask, 0);
        check("arst_acc", {acc_load, acc_en}, 2'b00);
        check("arst_out", {out_valid, done}, 2'b00);
        check("arst_out_idx", out_idx, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        start_layer(48, 2, s);  wait_done();

        start_layer(17, 2, s);
        d = s + 7 + 4;
        while (cyc < d) @(negedge clk);
        num_in  = 11'd33;
        num_out = 7'd2;
        start   = 1'b1;
        @(negedge clk);
        push_layer(cyc, 33, 2);
        @(negedge clk);
        start = 1'b0;
        wait_done();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
